// File: rtl/config_chain_pkg.sv
// ----------------------------------------------------------------------------
// config_chain_pkg
// Shared types and sizing helpers for the configuration scan chain.
//   - cfg_state_e     : loader FSM states (IDLE, SHIFT, COMMIT)
//   - cnt_width()     : bits needed to hold a count of 0..max_val
//   - words_per_load(): ceil(chain_len / data_width)
//   - last_word_bits(): bits of the final word that actually get shifted
//   - DEF_*           : sizing for the default 8-bit / 64-bit chain
// ----------------------------------------------------------------------------
package config_chain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int words_per_load(input int chain_len, input int data_width);
        return (chain_len + data_width - 1) / data_width;
    endfunction

    // The final word may be only partly used; its upper bits are dropped.
    function automatic int last_word_bits(input int chain_len, input int data_width);
        return chain_len - (words_per_load(chain_len, data_width) - 1) * data_width;
    endfunction

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_CHAIN_LEN      = 64;
    localparam int DEF_WORDS_PER_LOAD = words_per_load(DEF_CHAIN_LEN, DEF_DATA_WIDTH);
    localparam int DEF_LAST_WORD_BITS = last_word_bits(DEF_CHAIN_LEN, DEF_DATA_WIDTH);

endpackage

// File: rtl/config_scan_chain_if.sv
// ----------------------------------------------------------------------------
// config_scan_chain_if
// Load-side bus of the configuration scan chain.
//   start    : begin a load (honoured only when the chain is idle)
//   abort    : cancel the load in progress
//   in_valid : in_data carries a word
//   in_data  : configuration word, bit 0 shifted first
//   in_ready : chain can take a word this cycle
// master = protocol front-end, slave = scan chain.
// ----------------------------------------------------------------------------
interface config_scan_chain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  abort;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output start, output abort, output in_valid, output in_data,
                    input  in_ready);
    modport slave  (input  start, input  abort, input  in_valid, input  in_data,
                    output in_ready);
endinterface

// File: rtl/config_word_serializer.sv
// ----------------------------------------------------------------------------
// config_word_serializer
// One-word buffer that turns a DATA_WIDTH word into a bit stream, LSB first.
//   CK, RSTN   : clock, synchronous active-low reset
//   clr        : drop the buffered word
//   load       : capture load_data; load_bits of it will be shifted
//   load_data  : word to serialize
//   load_bits  : number of valid bits in load_data (1..DATA_WIDTH)
//   shift      : consume bit_out this cycle
//   bit_out    : current bit (buffer bit 0)
//   bit_valid  : bit_out holds an unshifted stream bit
//   can_accept : buffer empty, or its last bit leaves this cycle
// ----------------------------------------------------------------------------
module config_word_serializer
    import config_chain_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int IW         = cnt_width(DATA_WIDTH)
) (
    input  logic                  CK,
    input  logic                  RSTN,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [IW-1:0]         load_bits,
    input  logic                  shift,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  can_accept
);

    logic [DATA_WIDTH-1:0] sh_buf;
    logic [IW-1:0]         bits_left;
    logic                  last_bit;

    assign bit_out    = sh_buf[0];
    assign bit_valid  = (bits_left != '0);
    assign last_bit   = (bits_left == IW'(1));
    assign can_accept = !bit_valid || last_bit;

    // A load arriving while the last bit leaves overwrites the buffer; the
    // departing bit was already taken combinationally from sh_buf[0].
    always_ff @(posedge CK) begin
        if (!RSTN || clr) begin
            sh_buf    <= '0;
            bits_left <= '0;
        end else if (load) begin
            sh_buf    <= load_data;
            bits_left <= load_bits;
        end else if (shift && bit_valid) begin
            sh_buf    <= sh_buf >> 1;
            bits_left <= bits_left - IW'(1);
        end
    end

endmodule

// File: rtl/config_scan_chain.sv
// ----------------------------------------------------------------------------
// config_scan_chain
// CHAIN_LEN-bit configuration scan chain with word loader and shadow register.
// Words arrive over the load bus, are serialized one bit per cycle into the
// chain, and the full chain is copied to Q in one step at commit.
//   CK, RSTN : clock, synchronous active-low reset
//   ld       : load bus (start, abort, in_valid, in_data, in_ready)
//   busy     : load in progress (SHIFT or COMMIT)
//   done     : one-cycle pulse, new Q visible in the same cycle
//   SO       : chain[0], for readback / daisy-chaining
//   Q        : committed configuration bits
// ----------------------------------------------------------------------------
module config_scan_chain
    import config_chain_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   CHAIN_LEN  = 64,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic                  CK,
    input  logic                  RSTN,
    config_scan_chain_if.slave    ld,
    output logic                  busy,
    output logic                  done,
    output logic                  SO,
    output logic [CHAIN_LEN-1:0]  Q
);

    localparam int WORDS     = words_per_load(CHAIN_LEN, DATA_WIDTH);
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, DATA_WIDTH);
    localparam int BW        = cnt_width(CHAIN_LEN);
    localparam int WW        = cnt_width(WORDS);
    localparam int IW        = cnt_width(DATA_WIDTH);

    cfg_state_e           state, state_nxt;
    logic [CHAIN_LEN-1:0] chain, chain_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [WW-1:0]        word_cnt;

    logic          sr_clr, in_ready, accept, shift_en, last_shift, commit_now;
    logic          bit_out, bit_valid, can_accept;
    logic [IW-1:0] load_bits;

    // word_cnt < WORDS is the same test as accepted*DATA_WIDTH < CHAIN_LEN.
    assign in_ready   = (state == SHIFT) && can_accept && (word_cnt < WW'(WORDS));
    assign accept     = ld.in_valid && in_ready && !ld.abort;
    assign shift_en   = (state == SHIFT) && bit_valid && !ld.abort;
    assign last_shift = shift_en && (bit_cnt == BW'(CHAIN_LEN - 1));
    assign commit_now = (state == COMMIT) && !ld.abort;
    assign load_bits  = (word_cnt == WW'(WORDS - 1)) ? IW'(LAST_BITS) : IW'(DATA_WIDTH);

    assign ld.in_ready = in_ready;
    assign busy        = (state != IDLE);
    assign SO          = chain[0];

    // New bit enters at the top; after CHAIN_LEN shifts stream bit k sits in chain[k].
    generate
        if (CHAIN_LEN == 1) begin : g_chain_one
            assign chain_nxt = bit_out;
        end else begin : g_chain_many
            assign chain_nxt = {bit_out, chain[CHAIN_LEN-1:1]};
        end
    endgenerate

    config_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CK         (CK),
        .RSTN       (RSTN),
        .clr        (sr_clr),
        .load       (accept),
        .load_data  (ld.in_data),
        .load_bits  (load_bits),
        .shift      (shift_en),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .can_accept (can_accept)
    );

    always_ff @(posedge CK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sr_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (ld.start) begin
                    state_nxt = SHIFT;
                    sr_clr    = 1'b1;
                end
            end
            SHIFT: begin
                if (ld.abort) begin
                    state_nxt = IDLE;
                    sr_clr    = 1'b1;
                end else if (last_shift) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                // Leaves after one cycle either way; abort only suppresses the commit.
                state_nxt = IDLE;
                sr_clr    = ld.abort;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            chain    <= {CHAIN_LEN{RESET_VAL}};
            Q        <= {CHAIN_LEN{RESET_VAL}};
            done     <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            done <= commit_now;
            if (commit_now) Q <= chain;
            if (shift_en)   chain <= chain_nxt;
            if (sr_clr) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else begin
                if (shift_en) bit_cnt  <= bit_cnt + BW'(1);
                if (accept)   word_cnt <= word_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_config_scan_chain.sv
// ----------------------------------------------------------------------------
// tb_config_scan_chain
// Two chains: A (64 bits, 8-bit words, reset to ones) and B (10 bits, 8-bit
// words, reset to zeros). The driver computes each load's expected Q and
// done cycle from the word list and valid pattern and queues them; a monitor
// on the falling edge pops an entry on every done pulse and otherwise checks
// that Q holds its last committed value.
// ----------------------------------------------------------------------------
module tb_config_scan_chain;

    localparam int DW  = 8;
    localparam int CLA = 64;
    localparam int CLB = 10;

    logic CK = 1'b0;
    logic RSTN;
    always #5 CK = ~CK;

    logic          t_start, t_abort, t_valid, t_sel;
    logic [DW-1:0] t_data;

    config_scan_chain_if #(.DATA_WIDTH(DW)) if_a ();
    config_scan_chain_if #(.DATA_WIDTH(DW)) if_b ();

    assign if_a.start    = t_start & ~t_sel;
    assign if_a.abort    = t_abort & ~t_sel;
    assign if_a.in_valid = t_valid & ~t_sel;
    assign if_a.in_data  = t_data;
    assign if_b.start    = t_start & t_sel;
    assign if_b.abort    = t_abort & t_sel;
    assign if_b.in_valid = t_valid & t_sel;
    assign if_b.in_data  = t_data;

    logic           busy_a, done_a, so_a, busy_b, done_b, so_b;
    logic [CLA-1:0] q_a;
    logic [CLB-1:0] q_b;

    config_scan_chain #(.DATA_WIDTH(DW), .CHAIN_LEN(CLA), .RESET_VAL(1'b1)) u_a (
        .CK(CK), .RSTN(RSTN), .ld(if_a), .busy(busy_a), .done(done_a), .SO(so_a), .Q(q_a));
    config_scan_chain #(.DATA_WIDTH(DW), .CHAIN_LEN(CLB), .RESET_VAL(1'b0)) u_b (
        .CK(CK), .RSTN(RSTN), .ld(if_b), .busy(busy_b), .done(done_b), .SO(so_b), .Q(q_b));

    typedef struct {
        logic [63:0] q;
        int          cyc;
    } exp_t;

    exp_t        qa[$], qb[$];
    exp_t        ea, eb;
    logic [63:0] qm_a, qm_b;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    logic [7:0]  wbuf [16];
    bit          vbits [1024];

    always @(posedge CK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit vp(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return (rel % 2) == 0;
            default: return vbits[rel % 1024];
        endcase
    endfunction

    function automatic logic cur_rdy(input bit sel);
        return sel ? if_b.in_ready : if_a.in_ready;
    endfunction
    function automatic logic cur_so(input bit sel);
        return sel ? so_b : so_a;
    endfunction
    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    // Scoreboard monitor.
    always @(negedge CK) begin
        if (RSTN === 1'b1) begin
            if (done_a) begin
                chk("a_done_expected", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    chk("a_q_commit", q_a, ea.q);
                    chk("a_done_cycle", 64'(cyc), 64'(ea.cyc));
                    qm_a = ea.q;
                end
            end else begin
                chk("a_q_stable", q_a, qm_a);
            end
            if (done_b) begin
                chk("b_done_expected", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    chk("b_q_commit", 64'(q_b), eb.q);
                    chk("b_done_cycle", 64'(cyc), 64'(eb.cyc));
                    qm_b = eb.q;
                end
            end else begin
                chk("b_q_stable", 64'(q_b), qm_b);
            end
        end
    end

    // One load of n words from wbuf. abort_rel / start_rel / rst_rel (cycles
    // after the start cycle, -1 = none) inject abort, a stray start, or reset.
    task automatic run_load(input bit sel, input int n, input int vmode,
                            input int abort_rel, input int start_rel, input int rst_rel);
        int           cl, s, rel, t, a, done_rel, end_rel, i, k;
        bit           acc, rdy_checked;
        logic [127:0] full;
        logic [63:0]  qexp, mask, old;
        exp_t         e;
        cl   = sel ? CLB : CLA;
        full = '0;
        for (int j = 0; j < n; j++) full |= 128'(wbuf[j]) << (8 * j);
        mask = (cl == 64) ? '1 : ((64'd1 << cl) - 64'd1);
        qexp = full[63:0] & mask;
        // Each word needs a valid cycle once the previous word is on its last bit.
        t = 1; a = 1;
        for (int j = 0; j < n; j++) begin
            while (!vp(vmode, t)) t++;
            a = t;
            t = a + DW;
        end
        done_rel = a + (cl - (n - 1) * DW) + 2;
        old      = sel ? qm_b : qm_a;

        @(posedge CK); #1;
        t_sel = sel; t_start = 1'b1; s = cyc;
        if (abort_rel < 0 && rst_rel < 0) begin
            e.q = qexp; e.cyc = s + done_rel;
            if (sel) qb.push_back(e); else qa.push_back(e);
        end
        end_rel = (abort_rel >= 0) ? abort_rel : (rst_rel >= 0) ? rst_rel : done_rel + 1;
        @(posedge CK); #1;
        t_start = 1'b0; i = 0; rdy_checked = 1'b0;
        while (cyc - s <= end_rel) begin
            rel     = cyc - s;
            t_valid = (i < n) && vp(vmode, rel);
            t_data  = wbuf[i];
            t_abort = (rel == abort_rel);
            t_start = (rel == start_rel);
            RSTN    = (rel != rst_rel);
            @(negedge CK);
            acc = t_valid && cur_rdy(sel);
            if (abort_rel >= 0 && rel >= 2 && rel - 2 < 20 && rel < abort_rel)
                chk("so_partial", 64'(cur_so(sel)), 64'(old[rel-2]));
            if (i == n && !rdy_checked && RSTN) begin
                chk("rdy_low_after_last", 64'(cur_rdy(sel)), 64'd0);
                rdy_checked = 1'b1;
            end
            @(posedge CK); #1;
            if (acc) i++;
        end
        t_valid = 1'b0; t_abort = 1'b0; t_start = 1'b0;
        if (rst_rel >= 0) begin
            RSTN = 1'b1;
            qm_a = '1; qm_b = '0;
            qa.delete(); qb.delete();
        end
        k = 0;
        while ((sel ? qb.size() : qa.size()) != 0 && k < 300) begin
            @(posedge CK); #1;
            k++;
        end
        chk("done_seen", 64'(sel ? qb.size() : qa.size()), 64'd0);
        qa.delete(); qb.delete();
        @(negedge CK);
        chk("idle_after", 64'(cur_busy(sel)), 64'd0);
    endtask

    task automatic rand_words(input int n);
        for (int j = 0; j < n; j++) wbuf[j] = 8'($urandom);
    endtask

    initial begin
        RSTN = 1'b0; t_start = 0; t_abort = 0; t_valid = 0; t_sel = 0; t_data = '0;
        for (int j = 0; j < 1024; j++) vbits[j] = 1'($urandom_range(0, 1));
        for (int j = 0; j < 16; j++) wbuf[j] = '0;
        repeat (3) @(posedge CK);
        #1;
        qm_a = '1; qm_b = '0; RSTN = 1'b1;
        @(negedge CK);
        chk("rst_q_a", q_a, {64{1'b1}});
        chk("rst_so_a", 64'(so_a), 64'd1);
        chk("rst_done_a", 64'(done_a), 64'd0);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_rdy_a", 64'(if_a.in_ready), 64'd0);
        chk("rst_q_b", 64'(q_b), 64'd0);
        chk("rst_so_b", 64'(so_b), 64'd0);

        // start with no words: waits in SHIFT, chain and Q hold
        @(posedge CK); #1; t_sel = 1'b0; t_start = 1'b1;
        @(posedge CK); #1; t_start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge CK);
            chk("nv_busy", 64'(busy_a), 64'd1);
            chk("nv_rdy", 64'(if_a.in_ready), 64'd1);
            chk("nv_so", 64'(so_a), 64'd1);
            @(posedge CK); #1;
        end
        t_abort = 1'b1;
        @(posedge CK); #1; t_abort = 1'b0;
        @(negedge CK);
        chk("nv_abort_idle", 64'(busy_a), 64'd0);

        // continuous load 0x01..0x08
        for (int j = 0; j < 8; j++) wbuf[j] = 8'(j + 1);
        run_load(0, 8, 0, -1, -1, -1);
        chk("cont_q", q_a, 64'h0807060504030201);

        rand_words(8);
        run_load(0, 8, 2, -1, -1, -1);

        // same words, valid every other cycle
        for (int j = 0; j < 8; j++) wbuf[j] = 8'(j + 1);
        run_load(0, 8, 1, -1, -1, -1);
        chk("toggle_q", q_a, 64'h0807060504030201);

        for (int r = 0; r < 3; r++) begin
            rand_words(8);
            run_load(0, 8, 2, -1, -1, -1);
        end

        // short chain: partial final word
        wbuf[0] = 8'hFF; wbuf[1] = 8'hA5;
        run_load(1, 2, 0, -1, -1, -1);
        chk("short_q", 64'(q_b), 64'h1FF);
        for (int r = 0; r < 2; r++) begin
            rand_words(2);
            run_load(1, 2, 2, -1, -1, -1);
        end

        // abort after 20 shifts, then full reload of zeros
        rand_words(8);
        run_load(0, 8, 0, 22, -1, -1);
        for (int j = 0; j < 8; j++) wbuf[j] = '0;
        run_load(0, 8, 0, -1, -1, -1);
        chk("reload_zero_q", q_a, 64'd0);

        // start during COMMIT is ignored
        rand_words(8);
        run_load(0, 8, 0, -1, 66, -1);
        repeat (3) begin
            @(negedge CK);
            chk("post_commit_idle", 64'(busy_a), 64'd0);
        end

        // reset mid-SHIFT
        rand_words(8);
        run_load(0, 8, 2, -1, -1, 30);
        chk("midrst_q", q_a, {64{1'b1}});
        chk("midrst_so", 64'(so_a), 64'd1);
        repeat (80) @(negedge CK);
        chk("midrst_no_done_busy", 64'(busy_a), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
